// File: rtl/mem_seq_initiator.sv
// mem_seq_initiator: writes an LFSR pattern over a block of memory, reads it back and counts mismatches.
// Define MEMSEQ_TIMEOUT_EN to abort after 16 stalled cycles and expose the timeout output.
module mem_seq_initiator #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ADDR  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR-1:0]  start_addr,
  input  logic [ADDR:0]    num_loc,
  input  logic [31:0]      seed,
  output logic [ADDR-1:0]  addr,
  output logic [WIDTH-1:0] wdata,
  output logic             wrbar,
  output logic             valid,
  input  logic [WIDTH-1:0] rdata,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ADDR:0]    err_count,
`ifdef MEMSEQ_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [ADDR-1:0]  first_err_addr
);

  localparam logic [31:0]   POLY      = 32'h80200003;
  localparam logic [ADDR:0] DEPTH_CNT = (ADDR+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [ADDR-1:0] r_addr;
  logic [ADDR-1:0] r_base;
  logic [31:0]     r_lfsr;
  logic [31:0]     r_seed;
  logic [ADDR:0]   r_count;
  logic [ADDR:0]   r_remain;
  logic [ADDR:0]   r_err;
  logic [ADDR-1:0] r_first;
  logic            r_pass;

  logic            w_active;
  logic            w_hs;
  logic            w_last;
  logic            w_mismatch;
  logic            w_abort;
  logic [31:0]     w_seed_eff;
  logic [31:0]     w_lfsr_step;
  logic [ADDR:0]   w_count_eff;
  logic [ADDR:0]   w_err_next;

  assign w_active    = (r_state == WRITE) || (r_state == READ);
  assign w_hs        = w_active && ready;
  assign w_last      = (r_remain == (ADDR+1)'(1));
  assign w_seed_eff  = (seed == '0) ? 32'h1 : seed;
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? POLY : '0);
  assign w_count_eff = (num_loc > DEPTH_CNT) ? DEPTH_CNT : num_loc;
  assign w_mismatch  = (r_state == READ) && w_hs && (rdata != r_lfsr[WIDTH-1:0]);
  assign w_err_next  = (w_mismatch && (r_err != '1)) ? r_err + 1'b1 : r_err;

`ifdef MEMSEQ_TIMEOUT_EN
  logic [4:0] r_to_cnt;
  logic       r_timeout;

  // The 16th consecutive stalled cycle aborts on its closing edge.
  assign w_abort = w_active && !ready && (r_to_cnt == 5'd15);
  assign timeout = r_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == IDLE && start)
        r_timeout <= 1'b0;
      else if (w_abort)
        r_timeout <= 1'b1;
      if (w_active && !ready && !w_abort)
        r_to_cnt <= r_to_cnt + 5'd1;
      else
        r_to_cnt <= '0;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    valid          = 1'b0;
    wrbar          = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    addr           = r_addr;
    wdata          = '0;
    pass           = r_pass;
    err_count      = r_err;
    first_err_addr = r_first;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          w_state_next = (num_loc == '0) ? FINISH : WRITE;
      end
      WRITE: begin
        valid = 1'b1;
        wrbar = 1'b1;
        wdata = r_lfsr[WIDTH-1:0];
        if (w_abort)
          w_state_next = FINISH;
        else if (w_hs && w_last)
          w_state_next = READ;
      end
      READ: begin
        valid = 1'b1;
        if (w_abort || (w_hs && w_last))
          w_state_next = FINISH;
      end
      FINISH: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= '0;
      r_base   <= '0;
      r_lfsr   <= 32'h1;
      r_seed   <= 32'h1;
      r_count  <= '0;
      r_remain <= '0;
      r_err    <= '0;
      r_first  <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base   <= start_addr;
            r_addr   <= start_addr;
            r_seed   <= w_seed_eff;
            r_lfsr   <= w_seed_eff;
            r_count  <= w_count_eff;
            r_remain <= w_count_eff;
            r_err    <= '0;
            r_first  <= '0;
            r_pass   <= (num_loc == '0);
          end
        end
        WRITE, READ: begin
          if (w_hs) begin
            r_err <= w_err_next;
            if (w_mismatch && (r_err == '0))
              r_first <= r_addr;
          end
          // pass is set on the edge entering FINISH so it is valid alongside done.
          if (w_abort) begin
            r_pass <= 1'b0;
          end else if (w_hs && w_last) begin
            if (r_state == WRITE) begin
              r_addr   <= r_base;
              r_lfsr   <= r_seed;
              r_remain <= r_count;
            end else begin
              r_pass <= (w_err_next == '0);
            end
          end else if (w_hs) begin
            r_addr   <= r_addr + 1'b1;
            r_lfsr   <= w_lfsr_step;
            r_remain <= r_remain - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_seq_initiator.sv
// Self-checking bench for mem_seq_initiator: directed and randomized sequences against a queue-based model.
`timescale 1ns/1ps
module tb_mem_seq_initiator;
  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int ADDR  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic [8:0]  num_loc;
  logic [31:0] seed;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        wrbar;
  logic        valid;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [8:0]  err_count;
  logic [7:0]  first_err_addr;
`ifdef MEMSEQ_TIMEOUT_EN
  logic        timeout;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_seq_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .num_loc(num_loc),
    .seed(seed), .addr(addr), .wdata(wdata), .wrbar(wrbar), .valid(valid),
    .rdata(rdata), .ready(ready), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
`ifdef MEMSEQ_TIMEOUT_EN
    .timeout(timeout),
`endif
    .first_err_addr(first_err_addr)
  );

  // Memory model with an optional corrupted read location
  logic [31:0] mem [DEPTH];
  bit          corrupt_en = 1'b0;
  logic [7:0]  corrupt_addr = '0;
  logic [31:0] corrupt_mask = 32'h0000_0100;

  always @(posedge clk) if (valid && ready && wrbar) mem[addr] <= wdata;
  always_comb begin
    rdata = mem[addr];
    if (corrupt_en && addr == corrupt_addr) rdata = mem[addr] ^ corrupt_mask;
  end

  logic [7:0]  ob_addr[$];
  logic [31:0] ob_data[$];
  bit          ob_wr[$];
  bit          ob_done;
  int          ob_done_cyc, ob_valid_cnt, ob_unstable;
  logic        ob_pass;
  logic [8:0]  ob_err;
  logic [7:0]  ob_first;

  logic [7:0]  ex_addr[$];
  logic [31:0] ex_data[$];
  bit          ex_wr[$];
  int          ex_n, ex_err;
  logic [7:0]  ex_first;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  task automatic build_model(input logic [7:0] sa, input logic [8:0] nl, input logic [31:0] sd);
    logic [31:0] v;
    logic [7:0]  a;
    ex_addr.delete(); ex_data.delete(); ex_wr.delete();
    ex_n = (int'(nl) > DEPTH) ? DEPTH : int'(nl);
    ex_err = 0; ex_first = '0;
    for (int p = 0; p < 2; p++) begin
      v = (sd == 0) ? 32'h1 : sd;
      for (int k = 0; k < ex_n; k++) begin
        a = sa + 8'(k);
        ex_addr.push_back(a);
        ex_wr.push_back(p == 0);
        ex_data.push_back(v);
        v = lfsr_next(v);
      end
    end
    if (corrupt_en)
      for (int k = 0; k < ex_n; k++)
        if (8'(sa + 8'(k)) == corrupt_addr) begin
          if (ex_err == 0) ex_first = corrupt_addr;
          ex_err++;
        end
  endtask

  function automatic int first_diff();
    int n;
    n = (ob_addr.size() < ex_addr.size()) ? ob_addr.size() : ex_addr.size();
    for (int i = 0; i < n; i++)
      if (ob_addr[i] !== ex_addr[i] || ob_wr[i] !== ex_wr[i] || (ex_wr[i] && ob_data[i] !== ex_data[i]))
        return i;
    if (ob_addr.size() != ex_addr.size()) return n;
    return -1;
  endfunction

  // Drives one sequence (start in cycle 1) and records every handshake until done or budget expiry.
  task automatic run_seq(input logic [7:0] sa, input logic [8:0] nl, input logic [31:0] sd,
                         input int rmode, input int poke_cyc, input int budget);
    int hs, stall_left;
    bit held;
    logic [7:0]  h_addr;
    logic [31:0] h_data;
    logic        h_wr;
    ob_addr.delete(); ob_data.delete(); ob_wr.delete();
    ob_done = 0; ob_done_cyc = 0; ob_valid_cnt = 0; ob_unstable = 0;
    hs = 0; stall_left = 3; held = 0; h_addr = '0; h_data = '0; h_wr = 0;
    for (int cyc = 1; cyc <= budget && !ob_done; cyc++) begin
      @(posedge clk); #2;
      start = (cyc == 1) || (cyc == poke_cyc);
      if (cyc == 1) begin
        start_addr = sa; num_loc = nl; seed = sd;
      end else begin
        start_addr = 8'($urandom); num_loc = 9'($urandom_range(1, 200)); seed = $urandom;
      end
      case (rmode)
        0: ready = 1'b1;
        1: ready = ($urandom_range(0, 3) != 0);
        2: if (valid && hs == 2 && stall_left > 0) begin ready = 1'b0; stall_left--; end
           else ready = 1'b1;
        default: ready = 1'b0;
      endcase
      @(negedge clk);
      if (valid) ob_valid_cnt++;
      if (held && valid && (addr !== h_addr || wdata !== h_data || wrbar !== h_wr)) ob_unstable++;
      held = valid && !ready; h_addr = addr; h_data = wdata; h_wr = wrbar;
      if (valid && ready) begin
        ob_addr.push_back(addr); ob_data.push_back(wdata); ob_wr.push_back(wrbar);
        hs++;
      end
      if (done) begin
        ob_done = 1; ob_done_cyc = cyc; ob_pass = pass; ob_err = err_count; ob_first = first_err_addr;
      end
    end
    @(posedge clk); #2;
    start = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset();
    int vcnt;
    rst = 1'b0; start = 1'b0; ready = 1'b1; start_addr = '0; num_loc = '0; seed = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, wrbar, busy, done, pass, addr, wdata, err_count, first_err_addr} !== '0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b wrbar=%b busy=%b done=%b pass=%b addr=%h wdata=%h err=%0d first=%h, want all zero",
               valid, wrbar, busy, done, pass, addr, wdata, err_count, first_err_addr);
    end
    @(posedge clk); #2; rst = 1'b1;
    vcnt = 0;
    repeat (6) begin @(negedge clk); if (valid) vcnt++; end
    checks++;
    if (vcnt !== 0) begin failures++; $display("FAIL reset_idle: got %0d valid cycles, want 0", vcnt); end
  endtask

  task automatic test_basic();
    int d;
    build_model(8'd0, 9'd32, 32'd1);
    run_seq(8'd0, 9'd32, 32'd1, 0, 0, 100);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL basic_seq: differs at transfer %0d, got %0d transfers, want %0d", d, ob_addr.size(), ex_addr.size()); end
    checks++;
    if (ob_data.size() == 0 || ob_data[0] !== 32'h1) begin failures++; $display("FAIL basic_first_wdata: got %h, want 00000001", ob_data.size() ? ob_data[0] : 32'hx); end
    checks++;
    if (ob_done_cyc !== 66) begin failures++; $display("FAIL basic_done_cycle: got %0d, want 66", ob_done_cyc); end
    checks++;
    if (ob_pass !== 1'b1 || ob_err !== 9'd0 || ob_first !== 8'd0) begin
      failures++; $display("FAIL basic_result: got pass=%b err=%0d first=%0d, want pass=1 err=0 first=0", ob_pass, ob_err, ob_first);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pass !== 1'b1) begin failures++; $display("FAIL basic_pass_hold: got %b, want 1", pass); end
  endtask

  task automatic test_wrap();
    int d;
    build_model(8'd250, 9'd10, 32'hCAFE_0001);
    run_seq(8'd250, 9'd10, 32'hCAFE_0001, 0, 0, 40);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL wrap_seq: differs at transfer %0d, got %0d transfers, want %0d", d, ob_addr.size(), ex_addr.size()); end
    checks++;
    if (ob_addr.size() == 20 && (ob_addr[6] !== 8'd0 || ob_addr[19] !== 8'd3)) begin
      failures++; $display("FAIL wrap_addr: got %0d/%0d, want 0/3", ob_addr[6], ob_addr[19]);
    end
  endtask

  task automatic test_corrupt();
    int d;
    corrupt_en = 1'b1; corrupt_addr = 8'd5;
    build_model(8'd0, 9'd16, $urandom);
    run_seq(8'd0, 9'd16, ex_data[0], 1, 0, 200);
    d = first_diff();
    checks++;
    if (!ob_done || d != -1) begin failures++; $display("FAIL corrupt_seq: done=%0d differs at %0d, want done=1 no difference", ob_done, d); end
    checks++;
    if (ob_err !== 9'd1 || ob_first !== 8'd5 || ob_pass !== 1'b0) begin
      failures++; $display("FAIL corrupt_result: got err=%0d first=%0d pass=%b, want err=1 first=5 pass=0", ob_err, ob_first, ob_pass);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_stall();
    int d;
    build_model(8'd60, 9'd8, 32'h0BAD_F00D);
    run_seq(8'd60, 9'd8, 32'h0BAD_F00D, 2, 0, 60);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL stall_seq: differs at transfer %0d, got %0d transfers, want %0d", d, ob_addr.size(), ex_addr.size()); end
    checks++;
    if (ob_unstable !== 0) begin failures++; $display("FAIL stall_stable: got %0d unstable cycles, want 0", ob_unstable); end
    checks++;
    if (ob_done_cyc !== 21) begin failures++; $display("FAIL stall_done_cycle: got %0d, want 21", ob_done_cyc); end
  endtask

  task automatic test_zero_and_busy();
    int d, vcnt;
    run_seq(8'd9, 9'd0, 32'h55, 0, 0, 10);
    checks++;
    if (ob_done_cyc !== 2 || ob_pass !== 1'b1 || ob_err !== 9'd0 || ob_valid_cnt !== 0) begin
      failures++; $display("FAIL zero_count: got done_cyc=%0d pass=%b err=%0d valids=%0d, want 2 1 0 0", ob_done_cyc, ob_pass, ob_err, ob_valid_cnt);
    end
    build_model(8'd30, 9'd4, 32'h77);
    run_seq(8'd30, 9'd4, 32'h77, 0, 3, 30);
    d = first_diff();
    checks++;
    if (d != -1 || ob_done_cyc !== 10) begin failures++; $display("FAIL busy_start_ignored: diff at %0d done_cyc=%0d, want none and 10", d, ob_done_cyc); end
    vcnt = 0;
    repeat (5) begin @(negedge clk); if (valid || busy) vcnt++; end
    checks++;
    if (vcnt !== 0) begin failures++; $display("FAIL busy_no_relaunch: got %0d active cycles, want 0", vcnt); end
  endtask

  task automatic test_clamp();
    int d;
    build_model(8'd17, 9'd300, 32'd0);
    run_seq(8'd17, 9'd300, 32'd0, 0, 0, 600);
    d = first_diff();
    checks++;
    if (d != -1) begin failures++; $display("FAIL clamp_seq: differs at transfer %0d, got %0d transfers, want %0d", d, ob_addr.size(), ex_addr.size()); end
    checks++;
    if (ob_done_cyc !== 514 || ob_pass !== 1'b1) begin failures++; $display("FAIL clamp_done: got cyc=%0d pass=%b, want 514 1", ob_done_cyc, ob_pass); end
  endtask

  task automatic test_random();
    int d;
    logic [7:0]  sa;
    logic [8:0]  nl;
    logic [31:0] sd;
    for (int it = 0; it < 5; it++) begin
      sa = 8'($urandom); nl = 9'($urandom_range(1, 300));
      sd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      corrupt_en = ($urandom_range(0, 1) == 1); corrupt_addr = sa + 8'($urandom_range(0, 20));
      build_model(sa, nl, sd);
      run_seq(sa, nl, sd, 1, 0, 4 * ex_n + 40);
      d = first_diff();
      checks++;
      if (!ob_done || d != -1) begin failures++; $display("FAIL rand_seq[%0d]: done=%0d diff at %0d, want done=1 no difference", it, ob_done, d); end
      checks++;
      if (ob_err !== 9'(ex_err) || ob_first !== ex_first || ob_pass !== (ex_err == 0)) begin
        failures++; $display("FAIL rand_result[%0d]: got err=%0d first=%0d pass=%b, want err=%0d first=%0d pass=%b",
                             it, ob_err, ob_first, ob_pass, ex_err, ex_first, ex_err == 0);
      end
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int d, vcnt;
    @(posedge clk); #2; start = 1'b1; start_addr = 8'd40; num_loc = 9'd20; seed = 32'h1234; ready = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (valid !== 1'b1 || wrbar !== 1'b1) begin failures++; $display("FAIL midrst_pre: got valid=%b wrbar=%b, want 1 1", valid, wrbar); end
    rst = 1'b0; #1;
    checks++;
    if ({valid, wrbar, busy, done, pass, addr, wdata, err_count, first_err_addr} !== '0) begin
      failures++; $display("FAIL midrst_async: got valid=%b wrbar=%b busy=%b addr=%h wdata=%h, want all zero", valid, wrbar, busy, addr, wdata);
    end
    @(posedge clk); #2; rst = 1'b1;
    vcnt = 0;
    repeat (6) begin @(negedge clk); if (valid) vcnt++; end
    checks++;
    if (vcnt !== 0) begin failures++; $display("FAIL midrst_idle: got %0d valid cycles, want 0", vcnt); end
    build_model(8'd40, 9'd20, 32'h1234);
    run_seq(8'd40, 9'd20, 32'h1234, 0, 0, 60);
    d = first_diff();
    checks++;
    if (d != -1 || ob_pass !== 1'b1) begin failures++; $display("FAIL midrst_recover: diff at %0d pass=%b, want none and 1", d, ob_pass); end
  endtask

`ifdef MEMSEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_seq(8'd3, 9'd4, 32'h9, 3, 0, 40);
    checks++;
    if (ob_done_cyc !== 18 || ob_pass !== 1'b0) begin failures++; $display("FAIL timeout_abort: got cyc=%0d pass=%b, want 18 0", ob_done_cyc, ob_pass); end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag: got %b, want 1", timeout); end
    run_seq(8'd3, 9'd2, 32'h9, 0, 0, 20);
    checks++;
    if (timeout !== 1'b0 || ob_pass !== 1'b1) begin failures++; $display("FAIL timeout_clear: got timeout=%b pass=%b, want 0 1", timeout, ob_pass); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_corrupt();
    test_stall();
    test_zero_and_busy();
    test_clamp();
    test_random();
    test_reset_mid_write();
`ifdef MEMSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_seq_initiator.md
MEM_SEQ_INITIATOR -- requirements
Module: mem_seq_initiator

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
- WIDTH, 32, data width, 1..32.
- DEPTH, 256, memory locations.
- ADDR, 8, address width.
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that launches a sequence; sampled only in IDLE.
- start_addr, in, ADDR, first location.
- num_loc, in, ADDR+1, location count.
- seed, in, 32, pattern seed.
- addr, out, ADDR, memory address.
- wdata, out, WIDTH, write data.
- wrbar, out, 1, 1=write, 0=read.
- valid, out, 1, request valid.
- rdata, in, WIDTH, read data from the memory.
- ready, in, 1, memory accepts/completes the request.
- busy, out, 1, sequence in progress.
- done, out, 1, one-cycle completion pulse.
- pass, out, 1, last sequence had zero mismatches; held until next start.
- err_count, out, ADDR+1, mismatches in last sequence; saturates at all-ones.
- first_err_addr, out, ADDR, address of first mismatch; 0 if none.

Function
REQ-003 The FSM SHALL have states IDLE, WRITE, READ and FINISH; IDLE->WRITE on start, WRITE->READ after last write handshake, READ->FINISH after last read handshake, FINISH->IDLE after one cycle with done=1.
REQ-004 A transfer SHALL complete on a rising edge where valid=1 and ready=1; addr, wdata and wrbar SHALL stay stable while valid=1 and ready=0.
REQ-005 After a handshake, the next request SHALL be presented in the following cycle, giving one transfer per cycle when ready is held high.
REQ-006 Location k (0-based) SHALL use address (start_addr+k) mod 2^ADDR, so wrap-around past the top address is allowed.
REQ-007 Effective count SHALL be min(num_loc, DEPTH); num_loc=0 SHALL go IDLE->FINISH directly with pass=1 and err_count=0.
REQ-008 Pattern generation:
- A 32-bit Galois LFSR, polynomial 0x80200003, SHALL load seed, or 32'h1 if seed=0, at WRITE entry and again at READ entry.
- The LFSR SHALL advance once per handshake.
- wdata and the expected read data SHALL be the LFSR's low WIDTH bits.
REQ-009 In READ, rdata SHALL be compared on each handshake edge; a mismatch SHALL increment err_count, and the first mismatch SHALL capture first_err_addr.
REQ-010 pass SHALL update to (err_count==0) in the cycle done pulses.
REQ-011 start SHALL be ignored while busy=1; busy=1 SHALL hold in WRITE, READ and FINISH.
REQ-012 wrbar SHALL be 1 in WRITE and 0 otherwise; valid SHALL be 0 in IDLE and FINISH.

Reset
REQ-013 rst=0 SHALL asynchronously force the following from any state, including mid-handshake:
- state=IDLE
- valid=0, wrbar=0
- addr=0, wdata=0
- busy=0, done=0, pass=0
- err_count=0, first_err_addr=0
- LFSR=32'h1
REQ-014 Reset release SHALL take effect synchronously with clk; no request SHALL be issued before the first start after reset.

Configuration
REQ-015 Macro MEMSEQ_TIMEOUT_EN:
- When defined, a 5-bit counter SHALL count consecutive cycles with valid=1 and ready=0.
- At 16 such cycles the FSM SHALL abort to FINISH with pass=0, and an extra output timeout (1 bit) SHALL stay 1 until the next start.
- When undefined, the FSM SHALL wait indefinitely for ready, and the timeout port SHALL not exist.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- ready tied 1, start_addr=0, num_loc=32, seed=1, error-free memory -> 32 writes then 32 reads back-to-back, first wdata=0x00000001, done at cycle 66 from start, pass=1, err_count=0.
- start_addr=250, num_loc=10 -> addresses 250..255 then 0..3 in both passes.
- Memory corrupts location 5 on read -> err_count=1, first_err_addr=5, pass=0.
- ready low for 3 cycles on transfer 2 -> addr and wdata held stable, no transfer skipped or repeated.
- num_loc=0 -> done one cycle after start, pass=1, no valid asserted; start asserted while busy -> ignored.
- rst low mid-WRITE -> valid=0 immediately; with MEMSEQ_TIMEOUT_EN and ready stuck 0 -> timeout=1, pass=0 after 16 cycles.
